param_serializer: RTL and testbench

Parameterised parallel-to-serial transmitter. Accepts a (2**LOG_WIDTH+1)-bit word over a valid/ready handshake and shifts it out on a single line with one start bit, LSB-first data and one stop bit. It is the transmit-side counterpart of the parallel word registers in the parameter/localparam transformation testcases. All internal widths are localparams derived from the parameters, so the block also exercises parameter resolution.

---
 rtl/param_serializer.sv | 141 ++++++++++++++
 tb/tb_param_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// param_serializer
//
// Parallel-to-serial transmitter. A (2**LOG_WIDTH+1)-bit word is taken over a
// valid/ready handshake. It is sent on a single line as one low start bit,
// the data bits LSB first, and one high stop bit. Each bit lasts CLKS_PER_BIT
// clock cycles.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   in        word to transmit, sampled only when a word is accepted
//   in_valid  in holds a valid word
//   in_ready  high while idle; a word is accepted when in_valid is also high
//   tx        serial line, idles high
//   busy      a frame is in progress (inverse of in_ready)
//   done      one-cycle pulse on the first idle cycle after each frame
// ---------------------------------------------------------------------------
module param_serializer #(
  parameter int LOG_WIDTH    = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [(2**LOG_WIDTH+1)-1:0] in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        done
);

  localparam int WORD_W     = 2**LOG_WIDTH + 1;
  localparam int FRAME_BITS = WORD_W + 2;
  localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shreg;
  logic              cnt_last;
  logic              idx_last;

  // With CLKS_PER_BIT=1 the counter never leaves 0 and every cycle ends a bit.
  assign cnt_last = (cnt == CNT_LAST);
  assign idx_last = (bit_idx == IDX_LAST);

  assign in_ready = (state == ST_IDLE);
  assign busy     = ~in_ready;

  // The line level depends only on the registered state and the shift register.
  // This keeps tx glitch-free relative to the handshake inputs. It also makes
  // tx fall on the first cycle after the accept edge.
  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shreg[0];
      default:  tx = 1'b1;
    endcase
  end

  // Frame sequencer. A word is accepted only in idle, so in and in_valid are
  // ignored while a frame is running. done is set on the final stop-bit edge.
  // It is therefore high during exactly the first idle cycle, and is cleared
  // on every other edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg   <= in;
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          // The bit index holds at its last value when leaving DATA, so it
          // never exceeds WORD_W-1.
          if (cnt_last) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (idx_last) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // FRAME_BITS documents the frame length. It is not needed by the sequencer,
  // which counts start, data and stop bits separately.
  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
  if (FRAME_CYCLES < 3) begin : g_bad_params
    $error("param_serializer: CLKS_PER_BIT must be at least 1");
  end

endmodule

// File: tb/tb_param_serializer.sv
`timescale 1ns/1ps
// Testbench for param_serializer. Accepted words are predicted by a
// cycle-level handshake model and pushed into a queue. A negedge monitor pops
// each word when a frame starts. It then checks every line sample against the
// start/data/stop waveform built from that word. A second, minimal instance
// covers the LOG_WIDTH=1, CLKS_PER_BIT=1 corner.
module tb_param_serializer;

  localparam int LOG_WIDTH  = 3;
  localparam int CPB        = 4;
  localparam int WORD_W     = 2**LOG_WIDTH + 1;
  localparam int FRAME_BITS = WORD_W + 2;
  localparam int TOTAL      = FRAME_BITS * CPB;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [WORD_W-1:0] in_word = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, tx, busy, done;

  logic [2:0] c_in = 3'b000;
  logic       c_valid = 1'b0;
  logic       c_ready, c_tx, c_busy, c_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_serializer #(.LOG_WIDTH(LOG_WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .in(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );

  param_serializer #(.LOG_WIDTH(1), .CLKS_PER_BIT(1)) dut_corner (
    .clk(clk), .reset(reset), .in(c_in), .in_valid(c_valid),
    .in_ready(c_ready), .tx(c_tx), .busy(c_busy), .done(c_done)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // The line level for sample k of a frame carrying word w.
  function automatic logic frame_bit(input logic [WORD_W-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    else if (b <= WORD_W) return w[b-1];
    else return 1'b1;
  endfunction

  // Handshake model: a frame accepted on edge e keeps the block busy until
  // edge e+TOTAL+1. That is the earliest edge on which the next word can be
  // taken. Reset discards anything in flight.
  logic [WORD_W-1:0] exp_q[$];
  longint edge_no = 0;
  longint free_at = 0;
  bit     rst_seen = 1'b1;

  always @(posedge clk) begin
    rst_seen = reset;
    if (reset) begin
      free_at = edge_no + 1;
      exp_q.delete();
    end else if (in_valid && edge_no >= free_at) begin
      exp_q.push_back(in_word);
      free_at = edge_no + TOTAL + 1;
    end
    edge_no++;
  end

  // Monitor
  bit                cap = 1'b0;
  bit                done_due = 1'b0;
  int                samp = 0;
  logic [WORD_W-1:0] cur = '0;

  always @(negedge clk) begin
    if (rst_seen) begin
      cap      = 1'b0;
      done_due = 1'b0;
      checkOutput("reset_tx", tx, 1'b1);
      checkOutput("reset_ready", in_ready, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
    end else begin
      checkOutput("done_pulse", done, done_due);
      done_due = 1'b0;
      checkOutput("ready_vs_busy", in_ready, ~busy);
      if (!cap) begin
        checkOutput("frame_start", busy, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          cur  = exp_q.pop_front();
          cap  = 1'b1;
          samp = 0;
        end else begin
          checkOutput("idle_tx", tx, 1'b1);
        end
      end
      if (cap) begin
        checkOutput("frame_busy", busy, 1'b1);
        checkOutput("frame_tx", tx, frame_bit(cur, samp));
        samp++;
        if (samp == TOTAL) begin
          cap      = 1'b0;
          done_due = 1'b1;
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WORD_W-1:0] w, input int hold);
    in_word  = w;
    in_valid = 1'b1;
    repeat (hold) stepCycle();
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      stepCycle();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_done: got timeout after %0d cycles, required done=1", bound);
    end
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || cap || busy) && n < bound) begin
      stepCycle();
      n++;
    end
    if (exp_q.size() > 0 || cap || busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: got still busy after %0d cycles, required idle", bound);
    end
    repeat (2) stepCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] cframe;

    // Reset held for three cycles, then ten idle cycles.
    reset = 1'b1;
    #1;
    repeat (3) stepCycle();
    reset = 1'b0;
    repeat (10) stepCycle();
    checkOutput("corner_idle_tx", c_tx, 1'b1);
    checkOutput("corner_idle_ready", c_ready, 1'b1);

    $display("[TB] single frame 9'h1A5");
    applyStimulus(9'h1A5, 1);
    waitIdle(200);

    $display("[TB] back-to-back 9'h000 then 9'h1FF");
    in_word  = 9'h000;
    in_valid = 1'b1;
    stepCycle();
    waitDone(200);
    in_word = 9'h1FF;
    stepCycle();
    in_valid = 1'b0;
    waitIdle(200);

    $display("[TB] handshake hold-off with 9'h0F0");
    applyStimulus(WORD_W'($urandom), 1);
    repeat (10) stepCycle();
    in_word  = 9'h0F0;
    in_valid = 1'b1;
    waitDone(200);
    stepCycle();
    in_valid = 1'b0;
    waitIdle(200);

    $display("[TB] reset during data bit 4");
    applyStimulus(9'h13C, 1);
    repeat (21) stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    repeat (3) stepCycle();
    applyStimulus(9'h055, 1);
    waitIdle(200);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 5)) stepCycle();
      applyStimulus(WORD_W'($urandom), $urandom_range(1, 60));
    end
    waitIdle(300);

    $display("[TB] corner LOG_WIDTH=1 CLKS_PER_BIT=1");
    c_in    = 3'b101;
    c_valid = 1'b1;
    stepCycle();
    c_valid = 1'b0;
    cframe  = {1'b1, c_in, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checkOutput("corner_tx", c_tx, cframe[i]);
      checkOutput("corner_busy", c_busy, 1'b1);
      checkOutput("corner_no_done", c_done, 1'b0);
      stepCycle();
    end
    checkOutput("corner_done", c_done, 1'b1);
    checkOutput("corner_ready", c_ready, 1'b1);
    checkOutput("corner_stop_tx", c_tx, 1'b1);
    stepCycle();
    checkOutput("corner_done_clear", c_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
